// File: rtl/teclado_pkg.sv
// teclado_pkg: key codes and FSM state encoding shared by the keypad amount front end.
package teclado_pkg;
    localparam logic [3:0] TECLA_BORRAR  = 4'hA;
    localparam logic [3:0] TECLA_RETRO   = 4'hB;
    localparam logic [3:0] TECLA_ACEPTAR = 4'hE;
    typedef enum logic [1:0] {IDLE, CAPTURA, CONVIERTE, ENTREGA} estado_t;
endpackage

// File: rtl/teclado_monto_if.sv
// teclado_monto_if: key strobes in, amount and status out.
interface teclado_monto_if;
    logic        habilitar;
    logic [3:0]  tecla;
    logic        tecla_stb;
    logic [31:0] monto;
    logic        monto_stb;
    logic [3:0]  digitos;
    logic        ocupado;
    logic        error_tecla;
    logic        timeout;
    modport master (output habilitar, tecla, tecla_stb,
                    input monto, monto_stb, digitos, ocupado, error_tecla, timeout);
    modport slave  (input habilitar, tecla, tecla_stb,
                    output monto, monto_stb, digitos, ocupado, error_tecla, timeout);
endinterface

// File: rtl/bcd_a_binario.sv
// bcd_a_binario: serial BCD to binary, one multiply-by-10 step per cycle, MSD first.
module bcd_a_binario #(
    parameter int MAX_DIGITOS = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [4*MAX_DIGITOS-1:0] bcd,
    output logic                     done,
    output logic [31:0]              resultado
);
    localparam int BW = 4 * MAX_DIGITOS;
    logic [BW-1:0] sr;
    logic [3:0]    idx;
    logic          run;
    logic [31:0]   acc;
    assign done      = run && idx == 4'(MAX_DIGITOS - 1);
    assign resultado = acc;
    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            idx <= '0;
            run <= 1'b0;
            acc <= '0;
        end else if (start) begin
            sr  <= bcd;
            idx <= '0;
            run <= 1'b1;
            acc <= '0;
        end else if (run) begin
            acc <= (acc << 3) + (acc << 1) + 32'(sr[BW-1 -: 4]);
            sr  <= sr << 4;
            idx <= idx + 4'd1;
            run <= !done;
        end
    end
endmodule

// File: rtl/teclado_monto.sv
// teclado_monto: keypad strobes to a 32-bit amount with edit keys and idle timeout.
module teclado_monto
    import teclado_pkg::*;
#(
    parameter int MAX_DIGITOS    = 9,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input logic            clk,
    input logic            reset,
    teclado_monto_if.slave bus
);
    localparam int BW = 4 * MAX_DIGITOS;
    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [CW-1:0] CNT_FIN = CW'(TIMEOUT_CICLOS - 1);
    localparam logic [3:0]    DIG_MAX = 4'(MAX_DIGITOS);
    estado_t       estado;
    logic          hab_q;
    logic [BW-1:0] buffer;
    logic [CW-1:0] cnt;
    logic [3:0]    digitos;
    logic [31:0]   monto, resultado;
    logic          monto_stb, ocupado, error_tecla, timeout, done, es_digito, acepta;
    assign es_digito = bus.tecla <= 4'd9;
    assign acepta = estado == CAPTURA && bus.habilitar && bus.tecla_stb &&
                    bus.tecla == TECLA_ACEPTAR && digitos != 4'd0;
    assign bus.monto       = monto;
    assign bus.monto_stb   = monto_stb;
    assign bus.digitos     = digitos;
    assign bus.ocupado     = ocupado;
    assign bus.error_tecla = error_tecla;
    assign bus.timeout     = timeout;
    bcd_a_binario #(.MAX_DIGITOS(MAX_DIGITOS)) u_conv (
        .clk       (clk),
        .reset     (reset),
        .start     (acepta),
        .bcd       (buffer),
        .done      (done),
        .resultado (resultado)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= IDLE;
            hab_q       <= 1'b0;
            buffer      <= '0;
            cnt         <= '0;
            digitos     <= '0;
            monto       <= '0;
            monto_stb   <= 1'b0;
            ocupado     <= 1'b0;
            error_tecla <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            hab_q       <= bus.habilitar;
            monto_stb   <= 1'b0;
            error_tecla <= 1'b0;
            timeout     <= 1'b0;
            case (estado)
                IDLE: if (bus.habilitar && !hab_q) begin
                    estado  <= CAPTURA;
                    buffer  <= '0;
                    digitos <= '0;
                    cnt     <= '0;
                end
                CAPTURA: if (!bus.habilitar) begin
                    estado  <= IDLE;
                    buffer  <= '0;
                    digitos <= '0;
                end else if (bus.tecla_stb) begin
                    cnt <= '0;
                    if (es_digito) begin
                        if (digitos == DIG_MAX)
                            error_tecla <= 1'b1;
                        else if (bus.tecla != 4'd0 || digitos != 4'd0) begin
                            buffer  <= (buffer << 4) | BW'(bus.tecla);
                            digitos <= digitos + 4'd1;
                        end
                    end else if (bus.tecla == TECLA_BORRAR) begin
                        buffer  <= '0;
                        digitos <= '0;
                    end else if (bus.tecla == TECLA_RETRO) begin
                        if (digitos != 4'd0) begin
                            buffer  <= buffer >> 4;
                            digitos <= digitos - 4'd1;
                        end
                    end else if (bus.tecla == TECLA_ACEPTAR) begin
                        if (acepta) begin
                            estado  <= CONVIERTE;
                            ocupado <= 1'b1;
                        end else
                            error_tecla <= 1'b1;
                    end else
                        error_tecla <= 1'b1;
                end else if (cnt == CNT_FIN) begin
                    timeout <= 1'b1;
                    buffer  <= '0;
                    digitos <= '0;
                    estado  <= IDLE;
                end else
                    cnt <= cnt + 1'b1;
                // aborting leaves monto untouched; the converter just runs out
                CONVIERTE: if (!bus.habilitar) begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                end else if (done)
                    estado <= ENTREGA;
                ENTREGA: begin
                    monto     <= resultado;
                    monto_stb <= 1'b1;
                    digitos   <= '0;
                    ocupado   <= 1'b0;
                    estado    <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_teclado_monto.sv
// tb_teclado_monto: directed and random key sequences against a digit-queue reference model.
module tb_teclado_monto;
    localparam int MAXD = 9;
    localparam int TMO  = 1000;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int q[$];
    logic [31:0] prev_monto = '0;
    teclado_monto_if bus ();
    teclado_monto #(.MAX_DIGITOS(MAXD), .TIMEOUT_CICLOS(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic arm();
        bus.habilitar = 1'b0;
        tick();
        bus.habilitar = 1'b1;
        tick();
        q.delete();
    endtask
    task automatic press(input int k, output bit accepted);
        bit err = 0;
        longint unsigned v = 0;
        int n = 0;
        accepted = 0;
        if (k <= 9) begin
            if (q.size() == MAXD) err = 1;
            else if (!(k == 0 && q.size() == 0)) q.push_back(k);
        end else if (k == 10) q.delete();
        else if (k == 11) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (k == 14) begin
            if (q.size() == 0) err = 1;
            else accepted = 1;
        end else err = 1;
        bus.tecla = 4'(k);
        bus.tecla_stb = 1'b1;
        tick();
        bus.tecla_stb = 1'b0;
        chk("error_tecla", 32'(bus.error_tecla), 32'(err));
        if (accepted) begin
            foreach (q[i]) v = v * 10 + longint'(q[i]);
            q.delete();
            chk("ocupado", 32'(bus.ocupado), 32'd1);
            while (!bus.monto_stb && n < 40) begin
                tick();
                n++;
            end
            chk("latencia", n, MAXD + 1);
            chk("monto", bus.monto, 32'(v));
            prev_monto = 32'(v);
            tick();
            chk("stb_pulso", 32'(bus.monto_stb), 32'd0);
            chk("digitos_fin", 32'(bus.digitos), 32'd0);
        end else begin
            chk("digitos", 32'(bus.digitos), q.size());
            chk("stb_quieto", 32'(bus.monto_stb), 32'd0);
        end
    endtask
    task automatic seq(input int keys[$]);
        bit a;
        foreach (keys[i]) press(keys[i], a);
    endtask
    initial begin
        bit a;
        int k, r;
        bus.habilitar = 1'b0;
        bus.tecla = '0;
        bus.tecla_stb = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_monto", bus.monto, 32'd0);
        chk("rst_digitos", 32'(bus.digitos), 32'd0);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_stb", 32'(bus.monto_stb), 32'd0);
        arm();
        seq('{1, 0, 0, 14});
        arm();
        seq('{0, 0, 9, 1, 0, 0, 11, 11, 14});
        arm();
        seq('{9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 14});
        chk("max_valor", bus.monto, 32'h3B9AC9FF);
        arm();
        seq('{14, 5, 10, 7, 12, 13, 15, 14});
        arm();
        press(3, a);
        repeat (TMO - 1) tick();
        chk("timeout_pronto", 32'(bus.timeout), 32'd0);
        tick();
        chk("timeout", 32'(bus.timeout), 32'd1);
        tick();
        chk("timeout_pulso", 32'(bus.timeout), 32'd0);
        bus.tecla = 4'hE;
        bus.tecla_stb = 1'b1;
        tick();
        bus.tecla_stb = 1'b0;
        chk("idle_ignora", 32'(bus.error_tecla), 32'd0);
        arm();
        seq('{4, 2});
        bus.tecla = 4'hE;
        bus.tecla_stb = 1'b1;
        tick();
        bus.tecla_stb = 1'b0;
        repeat (3) tick();
        bus.habilitar = 1'b0;
        r = 0;
        repeat (20) begin
            tick();
            if (bus.monto_stb) r++;
        end
        chk("aborto_stb", r, 0);
        chk("aborto_monto", bus.monto, prev_monto);
        chk("aborto_ocupado", 32'(bus.ocupado), 32'd0);
        arm();
        seq('{5, 6});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_monto", bus.monto, 32'd0);
        chk("rst2_digitos", 32'(bus.digitos), 32'd0);
        chk("rst2_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst2_err", 32'(bus.error_tecla), 32'd0);
        chk("rst2_tmo", 32'(bus.timeout), 32'd0);
        prev_monto = '0;
        for (int t = 0; t < 30; t++) begin
            arm();
            a = 0;
            for (int j = 0; j < 16 && !a; j++) begin
                repeat ($urandom_range(0, 3)) tick();
                r = $urandom_range(0, 99);
                k = r < 75 ? int'($urandom_range(0, 9)) : r < 83 ? 11 : r < 86 ? 10 :
                    r < 91 ? 14 : int'($urandom_range(12, 15));
                press(k, a);
            end
            if (!a) begin
                if (q.size() == 0) press(7, a);
                press(14, a);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
